sound_cmd_link: RTL and testbench
=================================

Name: sound_cmd_link

Overview:
- Main-board end of the main/sound mailbox link; the sound board's SIN/SOUT registers are the responder.
- Buffers command bytes from a producer in a small FIFO and issues paced bus cycles on the main-CPU mailbox interface.
- Bus map: write 0x4400 = SIN, read 0x4400 = SOUT, read 0x4401 = status (bit7 SIN busy, bit6 SOUT full).
- Pushes a command only when SIN is free, drains SOUT into a reply register, and sits between the command producer and the sound_top bus inputs.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2.
- POLL_GAP, 3: idle ena ticks between successive status polls.
- TIMEOUT_POLLS, 255: busy polls before a command is dropped (Optional Feature only).

Ports:
- clk_12  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ena  in  1  one-clk_12 strobe at the 1.5 MHz sound-bus rate; bounds every bus cycle.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  producer offers cmd_data.
- cmd_ready  out  1  FIFO not full; push when cmd_valid&&cmd_ready.
- reply_data  out  8  last SOUT byte.
- reply_valid  out  1  reply_data holds an unconsumed byte.
- reply_ack  in  1  consumer takes the reply.
- bus_address  out  16  to sound cpu_address.
- bus_data_out  out  8  to sound cpu_data_out.
- bus_read_nwrite  out  1  to sound_read_nwrite.
- bus_data_in  in  8  from sound_data_out.
- cmd_pending  out  1  FIFO non-empty or write in flight.
- timeout  out  1  sticky drop flag (Optional Feature).

Behaviour:
- Reset values: bus_address=0x0000, bus_read_nwrite=1, bus_data_out=0x00, reply_data=0x00, reply_valid=0, cmd_pending=0, timeout=0, FIFO empty, cmd_ready=1, FSM in IDLE, gap counter 0.
- Idle bus: address 0x0000, read_nwrite=1, so no mailbox side effects.
- Bus cycle timing: outputs change only on an ena clk_12 edge and hold until the next ena (one 1.5 MHz period).
- bus_data_in is sampled on the ena edge that ends a read cycle.
- FSM states:
  - IDLE: counts POLL_GAP ena ticks, then enters POLL; enters POLL immediately if the FIFO is non-empty and the gap has expired.
  - POLL: drives 0x4401 read. At the ending ena:
    - if status bit6=1 and reply_valid=0 → READ;
    - else if bit7=0 and FIFO non-empty → WRITE;
    - else → IDLE, gap counter reloads.
  - READ: drives 0x4400 read. At the ending ena, reply_data<=bus_data_in and reply_valid<=1, then → IDLE.
  - WRITE: drives 0x4400, read_nwrite=0, bus_data_out=FIFO head for exactly one ena period. At the ending ena the FIFO pops, then → IDLE with zero gap.
- Reply priority: a pending reply is read before a command is written.
- Reply backpressure: while reply_valid=1, SOUT is never read; its byte stays in the sound board, so no loss.
- reply_ack clears reply_valid the next clk_12. If reply_ack and a READ completion land on the same edge, the new byte wins and reply_valid stays 1.
- FIFO push and pop on the same clk_12 edge are both honoured; count is unchanged.
- Full FIFO: cmd_ready=0 and cmd_valid is ignored.
- cmd_ready is combinational from the FIFO count only.
- Pointers wrap modulo CMD_DEPTH. Count width is clog2(CMD_DEPTH)+1.
- cmd_pending = (count≠0) || state==WRITE.
- Reset asserted mid-cycle returns the bus to idle on the next clk_12 edge regardless of ena; FIFO and reply are cleared.

Optional Feature:
- Macro: SOUND_CMD_LINK_TIMEOUT_EN.
- Enabled:
  - A busy counter increments on each POLL ending with bit7=1 while the FIFO is non-empty, and clears on any WRITE or on reset.
  - When it reaches TIMEOUT_POLLS, the FIFO head is popped without a bus write, timeout sets (sticky until reset), and the counter clears.
- Disabled: the link waits indefinitely for SIN free; timeout is tied 0 and no counter is synthesised.

Test Plan:
- Reset held 3 clks mid-WRITE → next edge shows bus_address=0x0000, read_nwrite=1, cmd_ready=1, reply_valid=0.
- Push 0x5A with model status 0x00 → POLL of 0x4401, then one ena-period write to 0x4400 with data 0x5A; model SIN=0x5A; cmd_pending falls after the WRITE.
- Push 0x01..0x05 with CMD_DEPTH=4 and status bit7 forced 1 → fifth push stalls (cmd_ready=0). Release bit7 → bytes 0x01..0x04 written in order, then 0x05 accepted.
- Model sets SOUT=0xC3 and bit6 with a command also queued → READ precedes WRITE; reply_data=0xC3, reply_valid=1.
- With reply_valid=1 and no ack, bit6=1 → no 0x4400 read issued. Ack → next POLL reads the byte.
- Timeout enabled, TIMEOUT_POLLS=4, bit7 stuck 1 → after 4 busy polls the head is dropped, timeout=1, no write seen. Macro off → bench confirms no drop after 1000 polls and timeout=0.

Source files
------------

// File: rtl/sound_cmd_link_if.sv
// Sound-bus mailbox interface between the main-board link and the sound board.
//   bus_address     : CPU address presented to the sound board
//   bus_data_out    : write data (valid when bus_read_nwrite=0)
//   bus_read_nwrite : 1 = read cycle, 0 = write cycle
//   bus_data_in     : read data returned by the sound board
// master = link side (sound_cmd_link), slave = sound board side.
interface sound_cmd_link_if;
  logic [15:0] bus_address;
  logic [7:0]  bus_data_out;
  logic        bus_read_nwrite;
  logic [7:0]  bus_data_in;

  modport master (
    output bus_address,
    output bus_data_out,
    output bus_read_nwrite,
    input  bus_data_in
  );

  modport slave (
    input  bus_address,
    input  bus_data_out,
    input  bus_read_nwrite,
    output bus_data_in
  );
endinterface

// File: rtl/sound_cmd_link.sv
// Main-board end of the main/sound mailbox link.
// Buffers command bytes in a small FIFO and issues paced bus cycles
// (one cycle per ena period) on the sound mailbox:
//   write 0x4400 = SIN, read 0x4400 = SOUT, read 0x4401 = status
//   (bit7 SIN busy, bit6 SOUT full).
// Ports:
//   clk_12, reset      : clock, synchronous active-high reset
//   ena                : 1.5 MHz bus-rate strobe, bounds every bus cycle
//   cmd_data/valid/ready : command producer handshake
//   reply_data/valid/ack : last SOUT byte and its consumer handshake
//   bus                : sound_cmd_link_if master modport
//   cmd_pending        : FIFO non-empty or write in flight
//   timeout            : sticky command-drop flag
// Optional feature macro: SOUND_CMD_LINK_TIMEOUT_EN (busy-poll timeout that
// drops the FIFO head). Without it timeout is tied 0.
module sound_cmd_link #(
  parameter int unsigned CMD_DEPTH     = 4,
  parameter int unsigned POLL_GAP      = 3,
  parameter int unsigned TIMEOUT_POLLS = 255
) (
  input  logic                  clk_12,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [7:0]            cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [7:0]            reply_data,
  output logic                  reply_valid,
  input  logic                  reply_ack,
  sound_cmd_link_if.master      bus,
  output logic                  cmd_pending,
  output logic                  timeout
);

  localparam int unsigned PW = $clog2(CMD_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_POLLS == 0) begin : g_param_check
    $error("sound_cmd_link: CMD_DEPTH must be a power of two >= 2 and TIMEOUT_POLLS >= 1");
  end

  typedef enum logic [1:0] {IDLE, POLL, READ, WRITE} state_t;

  state_t        state, state_next;
  logic [GW-1:0] gap_cnt, gap_next;

  logic [7:0]    mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_nonempty;
  logic          push, pop, drop;

  // ---------------- command FIFO ----------------
  assign fifo_nonempty = (count != '0);
  assign cmd_ready     = (count != CW'(CMD_DEPTH));
  assign push          = cmd_valid && cmd_ready;
  assign pop           = (ena && state == WRITE) || drop;
  assign cmd_pending   = fifo_nonempty || (state == WRITE);

  always_ff @(posedge clk_12) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_12) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  // ---------------- FSM: next state ----------------
  // IDLE polls once the gap has counted down; a zero gap (after WRITE/READ or
  // reset) polls on the very next ena, which serves queued commands promptly.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    if (ena) begin
      case (state)
        IDLE: begin
          if (gap_cnt == '0) state_next = POLL;
          else               gap_next   = gap_cnt - GW'(1);
        end
        POLL: begin
          if (bus.bus_data_in[6] && !reply_valid) begin
            state_next = READ;
          end else if (!bus.bus_data_in[7] && fifo_nonempty) begin
            state_next = WRITE;
          end else begin
            state_next = IDLE;
            gap_next   = GW'(POLL_GAP);
          end
        end
        READ: begin
          state_next = IDLE;
          gap_next   = '0;
        end
        WRITE: begin
          state_next = IDLE;
          gap_next   = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: bus outputs ----------------
  // Driven purely from the registered state, so they only move on ena edges.
  always_comb begin
    bus.bus_address     = 16'h0000;
    bus.bus_read_nwrite = 1'b1;
    bus.bus_data_out    = 8'h00;
    case (state)
      POLL:  bus.bus_address = 16'h4401;
      READ:  bus.bus_address = 16'h4400;
      WRITE: begin
        bus.bus_address     = 16'h4400;
        bus.bus_read_nwrite = 1'b0;
        bus.bus_data_out    = mem[rd_ptr];
      end
      default: ;
    endcase
  end

  // ---------------- reply register ----------------
  // A completing READ outranks a same-edge ack so the new byte is not lost.
  always_ff @(posedge clk_12) begin
    if (reset) begin
      reply_data  <= 8'h00;
      reply_valid <= 1'b0;
    end else if (ena && state == READ) begin
      reply_data  <= bus.bus_data_in;
      reply_valid <= 1'b1;
    end else if (reply_ack) begin
      reply_valid <= 1'b0;
    end
  end

  // ---------------- optional busy timeout ----------------
`ifdef SOUND_CMD_LINK_TIMEOUT_EN
  localparam int unsigned BW = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS + 1) : 1;

  logic [BW-1:0] busy_cnt;
  logic          timeout_q;
  logic          busy_poll;

  assign busy_poll = ena && state == POLL && bus.bus_data_in[7] && fifo_nonempty;
  assign drop      = busy_poll && (busy_cnt == BW'(TIMEOUT_POLLS - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk_12) begin
    if (reset) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (ena && state == WRITE) begin
      busy_cnt <= '0;
    end else if (drop) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b1;
    end else if (busy_poll) begin
      busy_cnt <= busy_cnt + BW'(1);
    end
  end
`else
  assign drop    = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sound_cmd_link.sv
// Self-checking bench for sound_cmd_link. A mailbox model plays the sound
// board (status/SOUT/SIN) and a transaction-level reference predicts which bus
// cycle each poll must lead to, the FIFO contents, the reply register and the
// timeout flag.
module tb_sound_cmd_link;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TPOLLS  = 4;
  localparam int unsigned ENA_DIV = 4;

  logic       clk_12 = 1'b0;
  logic       reset, ena, cmd_valid, cmd_ready, reply_valid, reply_ack;
  logic       cmd_pending, timeout;
  logic [7:0] cmd_data, reply_data;

  sound_cmd_link_if bus();

  sound_cmd_link #(.CMD_DEPTH(DEPTH), .POLL_GAP(3), .TIMEOUT_POLLS(TPOLLS)) dut (
    .clk_12      (clk_12),
    .reset       (reset),
    .ena         (ena),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .reply_data  (reply_data),
    .reply_valid (reply_valid),
    .reply_ack   (reply_ack),
    .bus         (bus),
    .cmd_pending (cmd_pending),
    .timeout     (timeout)
  );

  always #5 clk_12 = ~clk_12;

  // reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  wr_log[$];
  logic        busy7, sout_full, m_rv, m_timeout;
  logic [7:0]  sout_val, m_rd;
  int unsigned busy_polls, expect_next;   // 0 idle/poll, 1 read, 2 write
  int unsigned n_polls, n_reads, n_writes, n_drops, n_pushes;
  int unsigned seq, read_seq, write_seq, ena_cnt;
  logic        armed, prev_change_ok, prev_rnw;
  logic [15:0] prev_addr;
  logic [7:0]  prev_dout;
  int          vectors, miscompares;

  // One clk_12 period: called and returning at a negedge.
  task automatic step();
    bit          ready_m, read_end, ok;
    int unsigned kind;
    ready_m  = exp_q.size() < DEPTH;
    read_end = 0;
    if (bus.bus_read_nwrite && bus.bus_address == 16'h4401)      bus.bus_data_in = {busy7, sout_full, 6'b0};
    else if (bus.bus_read_nwrite && bus.bus_address == 16'h4400) bus.bus_data_in = sout_val;
    else                                                         bus.bus_data_in = 8'h00;
    ena     = (ena_cnt == ENA_DIV - 1);
    ena_cnt = ena ? 0 : ena_cnt + 1;
    if (armed && !reset) begin
      vectors++;
      if (!prev_change_ok && (bus.bus_address !== prev_addr || bus.bus_read_nwrite !== prev_rnw ||
                              bus.bus_data_out !== prev_dout)) begin
        miscompares++;
        $display("FAIL bus_hold: bus changed without ena, addr=%h rnw=%b (was %h %b)",
                 bus.bus_address, bus.bus_read_nwrite, prev_addr, prev_rnw);
      end
      vectors++;
      if (cmd_ready !== ready_m) begin
        miscompares++; $display("FAIL cmd_ready: got %b expected %b", cmd_ready, ready_m);
      end
      vectors++;
      if (reply_valid !== m_rv || (m_rv && reply_data !== m_rd)) begin
        miscompares++;
        $display("FAIL reply: got valid=%b data=%h expected valid=%b data=%h", reply_valid, reply_data, m_rv, m_rd);
      end
      vectors++;
      if (cmd_pending !== (exp_q.size() != 0)) begin
        miscompares++; $display("FAIL cmd_pending: got %b expected %b", cmd_pending, exp_q.size() != 0);
      end
      vectors++;
      if (timeout !== m_timeout) begin
        miscompares++; $display("FAIL timeout: got %b expected %b", timeout, m_timeout);
      end
      if (ena) begin
        seq++;
        if (bus.bus_address == 16'h0000 && bus.bus_read_nwrite)      kind = 0;
        else if (bus.bus_address == 16'h4401 && bus.bus_read_nwrite) kind = 1;
        else if (bus.bus_address == 16'h4400 && bus.bus_read_nwrite) kind = 2;
        else if (bus.bus_address == 16'h4400 && !bus.bus_read_nwrite) kind = 3;
        else kind = 4;
        ok = (expect_next == 0) ? (kind <= 1) : (expect_next == 1) ? (kind == 2) : (kind == 3);
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL bus_cycle: got kind %0d (addr=%h rnw=%b) expected kind class %0d",
                   kind, bus.bus_address, bus.bus_read_nwrite, expect_next);
        end
        expect_next = 0;
        case (kind)
          1: begin
            n_polls++;
            if (sout_full && !m_rv) expect_next = 1;
            else if (!busy7 && exp_q.size() != 0) expect_next = 2;
`ifdef SOUND_CMD_LINK_TIMEOUT_EN
            if (busy7 && exp_q.size() != 0) begin
              busy_polls++;
              if (busy_polls == TPOLLS) begin
                void'(exp_q.pop_front());
                n_drops++;
                m_timeout  = 1'b1;
                busy_polls = 0;
              end
            end
`endif
          end
          2: begin
            n_reads++; read_seq = seq; read_end = 1;
            m_rv = 1'b1; m_rd = sout_val; sout_full = 1'b0;
          end
          3: begin
            n_writes++; write_seq = seq; busy_polls = 0;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++; $display("FAIL write_data: got %h expected no write (FIFO empty)", bus.bus_data_out);
            end else begin
              if (bus.bus_data_out !== exp_q[0]) begin
                miscompares++; $display("FAIL write_data: got %h expected %h", bus.bus_data_out, exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
            wr_log.push_back(bus.bus_data_out);
          end
          default: ;
        endcase
      end
      if (cmd_valid && ready_m) begin
        exp_q.push_back(cmd_data);
        n_pushes++;
      end
      if (reply_ack && !read_end) m_rv = 1'b0;
    end
    prev_addr      = bus.bus_address;
    prev_rnw       = bus.bus_read_nwrite;
    prev_dout      = bus.bus_data_out;
    prev_change_ok = ena || reset;
    @(posedge clk_12);
    if (reset) begin
      exp_q.delete();
      m_rv = 1'b0; m_rd = 8'h00; m_timeout = 1'b0;
      busy_polls = 0; expect_next = 0; armed = 1'b1;
    end
    @(negedge clk_12);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int unsigned guard = 0;
    while (exp_q.size() >= DEPTH && guard < 2000) begin step(); guard++; end
    if (guard >= 2000) begin
      vectors++; miscompares++; $display("FAIL push_wait: got no space expected space within budget");
    end
    cmd_valid = 1'b1; cmd_data = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_writes(input int unsigned target, input string name);
    int unsigned guard = 0;
    while (n_writes < target && guard < 3000) begin step(); guard++; end
    if (n_writes < target) begin
      vectors++; miscompares++;
      $display("FAIL %s: got %0d writes expected %0d within budget", name, n_writes, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; reply_ack = 1'b0;
    busy7 = 1'b0; sout_full = 1'b0; sout_val = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    vectors++;
    if (bus.bus_address !== 16'h0000 || bus.bus_read_nwrite !== 1'b1 || bus.bus_data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%h rnw=%b dout=%h expected 0000 1 00",
               bus.bus_address, bus.bus_read_nwrite, bus.bus_data_out);
    end
    vectors++;
    if (reply_data !== 8'h00 || reply_valid !== 1'b0 || cmd_pending !== 1'b0 || timeout !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: got rd=%h rv=%b pend=%b to=%b rdy=%b expected 00 0 0 0 1",
               reply_data, reply_valid, cmd_pending, timeout, cmd_ready);
    end
  endtask

  task automatic test_single_write();
    int unsigned p0 = n_polls, w0 = n_writes;
    busy7 = 1'b0; sout_full = 1'b0;
    push_byte(8'h5A);
    wait_writes(w0 + 1, "single_write_wait");
    vectors++;
    if (wr_log.size() == 0 || wr_log[$] !== 8'h5A) begin
      miscompares++; $display("FAIL single_write: got last SIN %h expected 5a", wr_log.size() ? wr_log[$] : 8'hxx);
    end
    vectors++;
    if (n_polls <= p0) begin
      miscompares++; $display("FAIL single_poll: got %0d polls expected more than %0d", n_polls, p0);
    end
    step();
    vectors++;
    if (cmd_pending !== 1'b0) begin
      miscompares++; $display("FAIL single_pending: got %b expected 0", cmd_pending);
    end
  endtask

  task automatic test_fifo_full();
    int unsigned w0 = n_writes, l0 = wr_log.size(), pu0, guard = 0;
    logic [7:0] want;
    busy7 = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) push_byte(8'(i));
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_ready: got %b expected 0", cmd_ready);
    end
    pu0 = n_pushes;
    cmd_valid = 1'b1; cmd_data = 8'h05;
    repeat (12) step();
    vectors++;
    if (n_pushes != pu0 || cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_stall: got ready=%b expected 0 with 0x05 held off", cmd_ready);
    end
    busy7 = 1'b0;
    while (n_pushes == pu0 && guard < 2000) begin step(); guard++; end
    cmd_valid = 1'b0;
    wait_writes(w0 + 5, "full_drain_wait");
    for (int unsigned k = 0; k < 5; k++) begin
      want = 8'(k + 1);
      vectors++;
      if (wr_log.size() <= l0 + k || wr_log[l0 + k] !== want) begin
        miscompares++;
        $display("FAIL full_order[%0d]: got %h expected %h", k, (wr_log.size() > l0 + k) ? wr_log[l0 + k] : 8'hxx, want);
      end
    end
  endtask

  task automatic test_reply_priority();
    int unsigned r0 = n_reads, w0 = n_writes;
    busy7 = 1'b0; sout_val = 8'hC3; sout_full = 1'b1;
    push_byte(8'h77);
    wait_writes(w0 + 1, "prio_wait");
    vectors++;
    if (n_reads <= r0 || read_seq >= write_seq) begin
      miscompares++; $display("FAIL prio_order: got read seq %0d write seq %0d expected read first", read_seq, write_seq);
    end
    vectors++;
    if (reply_data !== 8'hC3 || reply_valid !== 1'b1) begin
      miscompares++; $display("FAIL prio_reply: got %h/%b expected c3/1", reply_data, reply_valid);
    end
  endtask

  task automatic test_backpressure();
    int unsigned r0 = n_reads, guard = 0;
    sout_val = 8'h3C; sout_full = 1'b1;
    repeat (200) step();
    vectors++;
    if (n_reads != r0 || reply_data !== 8'hC3 || reply_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold: got reads=%0d data=%h valid=%b expected reads=%0d data=c3 valid=1", n_reads, reply_data, reply_valid, r0);
    end
    reply_ack = 1'b1; step(); reply_ack = 1'b0;
    vectors++;
    if (reply_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_ack: got valid %b expected 0", reply_valid);
    end
    while (n_reads == r0 && guard < 2000) begin step(); guard++; end
    vectors++;
    if (n_reads == r0 || reply_data !== 8'h3C || reply_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_read: got data=%h valid=%b expected 3c/1", reply_data, reply_valid);
    end
    reply_ack = 1'b1; step(); reply_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int unsigned w0 = n_writes, guard = 0;
`ifdef SOUND_CMD_LINK_TIMEOUT_EN
    int unsigned d0 = n_drops;
`else
    int unsigned p0 = n_polls;
`endif
    busy7 = 1'b1; sout_full = 1'b0;
    push_byte(8'hEE);
`ifdef SOUND_CMD_LINK_TIMEOUT_EN
    while (n_drops == d0 && guard < 3000) begin step(); guard++; end
    step();
    vectors++;
    if (timeout !== 1'b1 || cmd_pending !== 1'b0 || n_writes != w0) begin
      miscompares++;
      $display("FAIL timeout_drop: got to=%b pend=%b writes=%0d expected 1 0 %0d", timeout, cmd_pending, n_writes, w0);
    end
    busy7 = 1'b0;
`else
    while (n_polls < p0 + 1000 && guard < 40000) begin step(); guard++; end
    vectors++;
    if (timeout !== 1'b0 || cmd_pending !== 1'b1 || n_writes != w0 || n_polls < p0 + 1000) begin
      miscompares++;
      $display("FAIL no_timeout: got to=%b pend=%b writes=%0d polls=%0d expected 0 1 %0d >=%0d",
               timeout, cmd_pending, n_writes, n_polls - p0, w0, 1000);
    end
    busy7 = 1'b0;
    wait_writes(w0 + 1, "no_timeout_drain");
    vectors++;
    if (wr_log.size() == 0 || wr_log[$] !== 8'hEE) begin
      miscompares++; $display("FAIL no_timeout_data: got %h expected ee", wr_log.size() ? wr_log[$] : 8'hxx);
    end
`endif
  endtask

  task automatic test_random();
    int unsigned guard = 0;
    for (int unsigned i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_data  = 8'($urandom);
      reply_ack = ($urandom_range(0, 3) == 0);
      if (!sout_full && $urandom_range(0, 15) == 0) begin
        sout_val = 8'($urandom); sout_full = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) busy7 = ~busy7;
      step();
    end
    cmd_valid = 1'b0; busy7 = 1'b0; reply_ack = 1'b1;
    while ((exp_q.size() != 0 || sout_full) && guard < 3000) begin step(); guard++; end
    reply_ack = 1'b0;
    step();
    vectors++;
    if (cmd_pending !== 1'b0 || sout_full) begin
      miscompares++; $display("FAIL random_drain: got pending=%b sout_full=%b expected 0 0", cmd_pending, sout_full);
    end
  endtask

  task automatic test_reset_mid_write();
    int unsigned guard = 0;
    busy7 = 1'b0; sout_full = 1'b0;
    push_byte(8'hA5);
    while (bus.bus_read_nwrite !== 1'b0 && guard < 2000) begin step(); guard++; end
    vectors++;
    if (bus.bus_read_nwrite !== 1'b0) begin
      miscompares++; $display("FAIL midwrite_reach: got rnw %b expected 0", bus.bus_read_nwrite);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (bus.bus_address !== 16'h0000 || bus.bus_read_nwrite !== 1'b1 || cmd_ready !== 1'b1 || reply_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midwrite_reset: got addr=%h rnw=%b rdy=%b rv=%b expected 0000 1 1 0",
               bus.bus_address, bus.bus_read_nwrite, cmd_ready, reply_valid);
    end
    step(); step();
    reset = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    armed = 1'b0; prev_change_ok = 1'b1; ena = 1'b0; ena_cnt = 0;
    bus.bus_data_in = 8'h00;
    m_rv = 1'b0; m_rd = 8'h00; m_timeout = 1'b0;
    busy_polls = 0; expect_next = 0;
    n_polls = 0; n_reads = 0; n_writes = 0; n_drops = 0; n_pushes = 0;
    seq = 0; read_seq = 0; write_seq = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; reply_ack = 1'b0;
    @(negedge clk_12);
    test_reset();
    test_single_write();
    test_fifo_full();
    test_reply_priority();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
